// File: rtl/distributor.sv
// Deserialising distributor: scatters a serial word stream round-robin into
// N_OUTPUTS lanes, then holds the packed frame until the consumer acknowledges.
module distributor #(
    parameter int DATA_WIDTH = 16,
    parameter int N_OUTPUTS  = 4,
    localparam int IDX_W     = $clog2(N_OUTPUTS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic                            valid_in,
    output logic                            ready_out,
    output logic [N_OUTPUTS*DATA_WIDTH-1:0] r_out,
    output logic                            frame_valid,
    input  logic                            frame_ack,
    output logic [IDX_W-1:0]                lane_idx
);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUTPUTS - 1);

    state_t                            state_q, state_d;
    logic [IDX_W-1:0]                  lane_idx_q, lane_idx_d;
    logic [N_OUTPUTS*DATA_WIDTH-1:0]   frame_q, frame_d;
    logic                              frame_valid_q, frame_valid_d;
    logic                              accept_s;

    // A new word may enter while filling, or in the same cycle the held frame is acknowledged.
    always_comb begin
        ready_out = (state_q == FILL) || ((state_q == HOLD) && frame_ack);
        accept_s  = valid_in && ready_out;
    end

    // Next-state, lane write and frame handshake.
    always_comb begin
        state_d       = state_q;
        lane_idx_d    = lane_idx_q;
        frame_d       = frame_q;
        frame_valid_d = frame_valid_q;
        case (state_q)
            FILL: begin
                if (accept_s) begin
                    for (int k = 0; k < N_OUTPUTS; k++) begin
                        if (lane_idx_q == IDX_W'(k)) begin
                            frame_d[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
                        end else begin
                            frame_d[k*DATA_WIDTH +: DATA_WIDTH] = frame_q[k*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    if (lane_idx_q == LAST_IDX) begin
                        lane_idx_d    = {IDX_W{1'b0}};
                        state_d       = HOLD;
                        frame_valid_d = 1'b1;
                    end else begin
                        lane_idx_d    = lane_idx_q + IDX_W'(1);
                    end
                end else begin
                    state_d = FILL;
                end
            end
            HOLD: begin
                if (frame_ack) begin
                    state_d       = FILL;
                    frame_valid_d = 1'b0;
                    // Word arriving with the ack opens the next frame in lane 0.
                    if (valid_in) begin
                        frame_d[DATA_WIDTH-1:0] = data_in;
                        lane_idx_d              = IDX_W'(1);
                    end else begin
                        lane_idx_d              = {IDX_W{1'b0}};
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            default: begin
                state_d       = FILL;
                lane_idx_d    = {IDX_W{1'b0}};
                frame_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= FILL;
            lane_idx_q    <= {IDX_W{1'b0}};
            frame_q       <= {(N_OUTPUTS*DATA_WIDTH){1'b0}};
            frame_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lane_idx_q    <= lane_idx_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        r_out       = frame_q;
        frame_valid = frame_valid_q;
        lane_idx    = lane_idx_q;
    end

endmodule
